// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared types, pitch table and song ROM for the tone sequencer
package tone_pkg;

  // Sequencer states: free play, auto playback, learn mode, finished
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_NOTE = 3'd1,
    A_GAP  = 3'd2,
    L_WAIT = 3'd3,
    L_HOLD = 3'd4,
    DONE   = 3'd5
  } state_e;

  // key is the index on the standard 8-key board (7 = c4, 0 = c5)
  typedef struct packed {
    logic [3:0] key;
    logic [1:0] beats;
  } note_t;

  // Half-periods at 100 MHz, indexed by pitch (0 = c4, rising)
  localparam int unsigned HALF [16] = '{
    191113, 170262, 151686, 143172, 127551, 113636, 101238, 95556,
    85131,  75843,  71586,  63776,  56818,  50619,  47778,  42566
  };

  localparam int ROM_LEN = 15;

  // Ode to Joy: E E F G G F E D C C D E E D D
  localparam note_t SONG_ROM [ROM_LEN] = '{
    '{4'd5, 2'd0}, '{4'd5, 2'd0}, '{4'd4, 2'd0}, '{4'd3, 2'd0}, '{4'd3, 2'd0},
    '{4'd4, 2'd0}, '{4'd5, 2'd0}, '{4'd6, 2'd0}, '{4'd7, 2'd0}, '{4'd7, 2'd0},
    '{4'd6, 2'd0}, '{4'd5, 2'd0}, '{4'd5, 2'd0}, '{4'd6, 2'd0}, '{4'd6, 2'd0}
  };

  // Pitch index of a ROM entry, independent of how many keys are fitted
  function automatic logic [3:0] rom_pitch(input note_t n);
    return 4'd7 - n.key;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave generator driven by a half-period count
module tone_gen #(
  parameter int CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             active_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             freq_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_q;
  logic             freq_q;
  logic             active_q;

  // Count 0..half-1 and toggle on the wrap; silence or a new pitch restarts from 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      half_q   <= '0;
      freq_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      active_q <= active_i;
      half_q   <= half_i;
      if (!active_i || (active_q && (half_i != half_q))) begin
        cnt_q  <= '0;
        freq_q <= 1'b0;
      end else if (cnt_q >= half_i - CNT_W'(1)) begin
        cnt_q  <= '0;
        freq_q <= ~freq_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign freq_o = freq_q;

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - free play, auto song playback and learn mode tone engine
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int NUM_KEYS       = 8,
  parameter int SONG_LEN       = 15,
  parameter int TICKS_PER_BEAT = 25_000_000,
  parameter int GAP_TICKS      = 2_500_000,
  parameter int TONE_SHIFT     = 0,
  parameter int CNT_W          = 20
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        AUTO_START,
  input  logic                        LEARN_START,
  input  logic [NUM_KEYS-1:0]         sw,
  output logic                        FREQ,
  output logic [NUM_KEYS-1:0]         Led,
  output logic [$clog2(SONG_LEN)-1:0] note_idx,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  mistakes
);

  localparam int IDX_W    = $clog2(SONG_LEN);
  localparam int TICK_MAX = (TICKS_PER_BEAT > GAP_TICKS) ? TICKS_PER_BEAT : GAP_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SONG_LEN - 1);
  localparam logic [TICK_W-1:0] BEAT_END = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [TICK_W-1:0] GAP_END  = TICK_W'(GAP_TICKS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [1:0]          beat_q, beat_d;
  logic [7:0]          mistakes_q, mistakes_d;
  logic                done_q, done_d;
  logic [NUM_KEYS-1:0] led_q, led_d;
  logic [NUM_KEYS-1:0] sw_q;

  note_t               cur_note;
  logic [3:0]          exp_pitch;
  logic [NUM_KEYS-1:0] exp_onehot;
  logic [NUM_KEYS-1:0] rise;
  logic                exp_hit;
  logic                exp_held;
  logic                free_on;
  logic [3:0]          free_pitch;
  logic                tone_on;
  logic [3:0]          tone_pitch;

  // One-hot key position of a song entry on this keyboard
  function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [IDX_W-1:0] i);
    logic [4:0] k;
    k = 5'(NUM_KEYS - 1) - {1'b0, rom_pitch(SONG_ROM[i])};
    return NUM_KEYS'(1) << k;
  endfunction

  assign cur_note   = SONG_ROM[idx_q];
  assign exp_pitch  = rom_pitch(cur_note);
  assign exp_onehot = key_onehot(idx_q);
  assign rise       = sw & ~sw_q;
  assign exp_hit    = |(rise & exp_onehot);
  assign exp_held   = |(sw & exp_onehot);

  // Free play sounds the highest pressed index, the lowest pitch
  always_comb begin
    free_on    = 1'b0;
    free_pitch = 4'd0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (sw[k]) begin
        free_on    = 1'b1;
        free_pitch = 4'(NUM_KEYS - 1 - k);
      end
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Song position, timing counters, score and LED registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_q      <= '0;
      tick_q     <= '0;
      beat_q     <= '0;
      mistakes_q <= '0;
      done_q     <= 1'b0;
      led_q      <= '0;
      sw_q       <= '0;
    end else begin
      idx_q      <= idx_d;
      tick_q     <= tick_d;
      beat_q     <= beat_d;
      mistakes_q <= mistakes_d;
      done_q     <= done_d;
      led_q      <= led_d;
      sw_q       <= sw;
    end
  end

  // Next state: start pulses override everything, AUTO_START over LEARN_START
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tick_d     = tick_q;
    beat_d     = beat_q;
    mistakes_d = mistakes_q;
    done_d     = done_q;
    if (AUTO_START) begin
      state_d = A_NOTE;
      idx_d   = '0;
      tick_d  = '0;
      beat_d  = '0;
      done_d  = 1'b0;
    end else if (LEARN_START) begin
      state_d    = L_WAIT;
      idx_d      = '0;
      mistakes_d = '0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        A_NOTE: begin
          if (tick_q == BEAT_END) begin
            tick_d = '0;
            if (beat_q == cur_note.beats) begin
              beat_d  = '0;
              state_d = A_GAP;
            end else begin
              beat_d = beat_q + 2'd1;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        A_GAP: begin
          if (tick_q == GAP_END) begin
            tick_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = A_NOTE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        L_WAIT: begin
          if (exp_hit) begin
            state_d = L_HOLD;
          end else if ((|rise) && (mistakes_q != 8'hFF)) begin
            mistakes_d = mistakes_q + 8'd1;
          end
        end
        L_HOLD: begin
          if (!exp_held) begin
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = L_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tone selection from the current state, LED contents for the next state
  always_comb begin
    tone_on    = 1'b0;
    tone_pitch = 4'd0;
    led_d      = '0;
    case (state_q)
      A_NOTE: begin
        tone_on    = 1'b1;
        tone_pitch = exp_pitch;
      end
      L_HOLD: begin
        tone_on    = exp_held;
        tone_pitch = exp_pitch;
      end
      IDLE, DONE: begin
        tone_on    = free_on;
        tone_pitch = free_pitch;
      end
      default: ;
    endcase
    case (state_d)
      A_NOTE, L_WAIT, L_HOLD: led_d = key_onehot(idx_d);
      IDLE, DONE:             led_d = sw;
      default:                led_d = '0;
    endcase
  end

  tone_gen #(
    .CNT_W(CNT_W)
  ) u_tone_gen (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .active_i(tone_on),
    .half_i  (CNT_W'(HALF[tone_pitch] >> TONE_SHIFT)),
    .freq_o  (FREQ)
  );

  assign Led      = led_q;
  assign note_idx = idx_q;
  assign busy     = (state_q == A_NOTE) || (state_q == A_GAP) ||
                    (state_q == L_WAIT) || (state_q == L_HOLD);
  assign done     = done_q;
  assign mistakes = mistakes_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - randomized self-checking bench for tone_sequencer
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        auto_s = 1'b0;
  logic        learn_s = 1'b0;
  logic [7:0]  sw = '0;
  logic        freq;
  logic [7:0]  led;
  logic [3:0]  nidx;
  logic        busy;
  logic        done;
  logic [7:0]  mist;

  logic [11:0] sw12 = '0;
  logic        freq12;
  logic [11:0] led12;
  logic [3:0]  nidx12;
  logic        busy12;
  logic        done12;
  logic [7:0]  mist12;

  int n_checks = 0;
  int n_fail = 0;

  int song_keys [15] = '{5, 5, 4, 3, 3, 4, 5, 6, 7, 7, 6, 5, 5, 6, 6};
  int half_full [8]  = '{191113, 170262, 151686, 143172, 127551, 113636, 101238, 95556};

  always #5 clk = ~clk;

  tone_sequencer #(
    .NUM_KEYS(8), .SONG_LEN(15), .TICKS_PER_BEAT(10), .GAP_TICKS(2), .TONE_SHIFT(12), .CNT_W(20)
  ) u_dut (
    .CLK(clk), .RESET(rst), .AUTO_START(auto_s), .LEARN_START(learn_s), .sw(sw),
    .FREQ(freq), .Led(led), .note_idx(nidx), .busy(busy), .done(done), .mistakes(mist)
  );

  tone_sequencer #(
    .NUM_KEYS(12), .SONG_LEN(15), .TICKS_PER_BEAT(10), .GAP_TICKS(2), .TONE_SHIFT(12), .CNT_W(20)
  ) u_dut12 (
    .CLK(clk), .RESET(rst), .AUTO_START(1'b0), .LEARN_START(1'b0), .sw(sw12),
    .FREQ(freq12), .Led(led12), .note_idx(nidx12), .busy(busy12), .done(done12), .mistakes(mist12)
  );

  function automatic int half_of_key(input int key);
    return half_full[7 - key] >> 12;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({freq, led, nidx, busy, done, mist} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {freq, led, nidx, busy, done, mist});
    end
    n_checks++;
    if ({freq12, led12, nidx12, busy12, done12, mist12} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs12: got %h want 0", {freq12, led12, nidx12, busy12, done12, mist12});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_free_play();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] pat;
      int key;
      int h;
      pat = (it == 0) ? 8'h80 : 8'($urandom_range(1, 255));
      key = 0;
      for (int k = 0; k < 8; k++) if (pat[k]) key = k;
      h = half_of_key(key);
      sw = pat;
      for (int s = 0; s < 3 * h; s++) begin
        n_checks++;
        if (freq !== 1'(((s / h) % 2))) begin
          n_fail++;
          $display("FAIL free_freq pat=%h s=%0d: got %b want %0d", pat, s, freq, (s / h) % 2);
        end
        if (s == 1) begin
          n_checks++;
          if (led !== pat) begin
            n_fail++;
            $display("FAIL free_led: got %h want %h", led, pat);
          end
        end
        @(negedge clk);
      end
      sw = '0;
      @(negedge clk);
      n_checks++;
      if (freq !== 1'b0) begin
        n_fail++;
        $display("FAIL free_release: got %b want 0", freq);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_twelve_key();
    sw12 = 12'h801;
    for (int s = 0; s < 2 * 46 + 4; s++) begin
      n_checks++;
      if (freq12 !== 1'(((s / 46) % 2))) begin
        n_fail++;
        $display("FAIL key12_freq s=%0d: got %b want %0d", s, freq12, (s / 46) % 2);
      end
      if (s == 1) begin
        n_checks++;
        if ({busy12, led12} !== {1'b0, 12'h801}) begin
          n_fail++;
          $display("FAIL key12_led: got %h want 801", {busy12, led12});
        end
      end
      @(negedge clk);
    end
    sw12 = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_auto();
    auto_s = 1'b1;
    @(negedge clk);
    auto_s = 1'b0;
    for (int c = 0; c < 180; c++) begin
      int n, j, h, ef;
      logic [7:0] el;
      n = c / 12;
      j = c % 12;
      h = half_of_key(song_keys[n]);
      el = (j < 10) ? 8'(1 << song_keys[n]) : 8'h00;
      ef = (j < 10) ? ((j / h) % 2) : ((j == 10) ? ((10 / h) % 2) : 0);
      n_checks++;
      if ({led, nidx, busy, done, freq} !== {el, 4'(n), 1'b1, 1'b0, 1'(ef)}) begin
        n_fail++;
        $display("FAIL auto_step c=%0d: got led=%h idx=%0d busy=%b done=%b freq=%b want led=%h idx=%0d busy=1 done=0 freq=%0d",
                 c, led, nidx, busy, done, freq, el, n, ef);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({done, busy, nidx} !== {1'b1, 1'b0, 4'd14}) begin
      n_fail++;
      $display("FAIL auto_done: got done=%b busy=%b idx=%0d want 1 0 14", done, busy, nidx);
    end
    learn_s = 1'b1;
    @(negedge clk);
    learn_s = 1'b0;
    n_checks++;
    if ({done, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL start_clears_done: got done=%b busy=%b want 0 1", done, busy);
    end
  endtask

  task automatic test_learn();
    int mist_m;
    int idx_m;
    int h;
    mist_m = 0;
    idx_m = 0;
    learn_s = 1'b1;
    @(negedge clk);
    learn_s = 1'b0;
    n_checks++;
    if ({led, nidx, mist, busy, done} !== {8'h20, 4'd0, 8'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL learn_start: got led=%h idx=%0d mist=%0d busy=%b done=%b want 20 0 0 1 0", led, nidx, mist, busy, done);
    end
    sw = 8'h80;
    @(negedge clk);
    sw = '0;
    @(negedge clk);
    mist_m = 1;
    n_checks++;
    if ({mist, nidx} !== {8'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL learn_wrong_key: got mist=%0d idx=%0d want 1 0", mist, nidx);
    end
    h = half_of_key(5);
    sw = 8'h20;
    @(negedge clk);
    for (int s = 0; s < 2 * h + 3; s++) begin
      n_checks++;
      if (freq !== 1'(((s / h) % 2))) begin
        n_fail++;
        $display("FAIL learn_hold_freq s=%0d: got %b want %0d", s, freq, (s / h) % 2);
      end
      @(negedge clk);
    end
    sw = '0;
    @(negedge clk);
    idx_m = 1;
    n_checks++;
    if ({nidx, freq, led} !== {4'(idx_m), 1'b0, 8'h20}) begin
      n_fail++;
      $display("FAIL learn_release: got idx=%0d freq=%b led=%h want 1 0 20", nidx, freq, led);
    end
    for (int n = 1; n < 15; n++) begin
      int ek, nw;
      logic [7:0] eoh, pat;
      ek = song_keys[n];
      eoh = 8'(1 << ek);
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        pat = 8'($urandom_range(1, 255)) & ~eoh;
        if (pat == 8'h00) pat = 8'(1 << ((ek + 1) % 8));
        sw = pat;
        @(negedge clk);
        sw = '0;
        @(negedge clk);
        if (mist_m < 255) mist_m++;
      end
      pat = eoh | (($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'h00);
      sw = pat;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      sw = '0;
      @(negedge clk);
      idx_m = (n < 14) ? n + 1 : 14;
      n_checks++;
      if ({mist, nidx} !== {8'(mist_m), 4'(idx_m)}) begin
        n_fail++;
        $display("FAIL learn_note n=%0d: got mist=%0d idx=%0d want %0d %0d", n, mist, nidx, mist_m, idx_m);
      end
    end
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL learn_done: got done=%b busy=%b want 1 0", done, busy);
    end
  endtask

  task automatic test_saturation();
    learn_s = 1'b1;
    @(negedge clk);
    learn_s = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sw = 8'h01;
      @(negedge clk);
      sw = '0;
      @(negedge clk);
      if (i == 253) begin
        n_checks++;
        if (mist !== 8'd254) begin
          n_fail++;
          $display("FAIL sat_254: got %0d want 254", mist);
        end
      end
    end
    n_checks++;
    if ({mist, nidx, busy} !== {8'd255, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_255: got mist=%0d idx=%0d busy=%b want 255 0 1", mist, nidx, busy);
    end
  endtask

  task automatic test_mid_song_reset();
    auto_s = 1'b1;
    @(negedge clk);
    auto_s = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({freq, busy, nidx, led, done, mist} !== 23'd0) begin
      n_fail++;
      $display("FAIL mid_song_reset: got freq=%b busy=%b idx=%0d led=%h done=%b mist=%0d want all 0",
               freq, busy, nidx, led, done, mist);
    end
    rst = 1'b0;
    sw = 8'h80;
    repeat (51) @(negedge clk);
    n_checks++;
    if (freq !== 1'b1) begin
      n_fail++;
      $display("FAIL tone_before_reset: got %b want 1", freq);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (freq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_kills_tone: got %b want 0", freq);
    end
    rst = 1'b0;
    sw = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_both_starts();
    auto_s = 1'b1;
    learn_s = 1'b1;
    @(negedge clk);
    auto_s = 1'b0;
    learn_s = 1'b0;
    n_checks++;
    if ({busy, led} !== {1'b1, 8'h20}) begin
      n_fail++;
      $display("FAIL both_start_enter: got busy=%b led=%h want 1 20", busy, led);
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if ({nidx, led} !== {4'd1, 8'h20}) begin
      n_fail++;
      $display("FAIL both_start_auto_wins: got idx=%0d led=%h want 1 20", nidx, led);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_free_play();
    test_twelve_key();
    test_auto();
    test_learn();
    test_saturation();
    test_mid_song_reset();
    test_both_starts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got still running want finished");
    $fatal(1);
  end

endmodule
